// File: rtl/tone_selector.sv
// Note-selection front end: synchronises switches/buttons, debounces the octave
// buttons and runs the manual / auto-scale state machine that picks freq_out.

module tone_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic in_clk,
    input  logic reset_n,
    input  logic level_sync,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          level;
    logic [CW-1:0] cnt;

    // press is registered, which adds the final edge of button-to-octave latency
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (level_sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= level_sync;
                cnt   <= '0;
                press <= level_sync;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module tone_selector #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int NOTE_CYCLES     = 25_000_000,
    parameter int GAP_CYCLES      = 2_500_000
) (
    input  logic        in_clk,
    input  logic        reset_n,
    input  logic [2:0]  sw,
    input  logic        auto_mode,
    input  logic        play_en,
    input  logic        oct_up_btn,
    input  logic        oct_dn_btn,
    output logic [31:0] freq_out,
    output logic [2:0]  note_idx,
    output logic [1:0]  octave,
    output logic        tone_on
);
    localparam int TMAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {MANUAL, AUTO_NOTE, AUTO_GAP} state_t;

    function automatic logic [11:0] note_hz(input logic [2:0] idx);
        case (idx)
            3'd0:    note_hz = 12'd262;
            3'd1:    note_hz = 12'd294;
            3'd2:    note_hz = 12'd330;
            3'd3:    note_hz = 12'd349;
            3'd4:    note_hz = 12'd392;
            3'd5:    note_hz = 12'd440;
            3'd6:    note_hz = 12'd494;
            default: note_hz = 12'd523;
        endcase
    endfunction

    // bit order: sw[2:0], auto_mode, play_en, oct_up_btn, oct_dn_btn
    logic [6:0] meta, sync;
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= {sw, auto_mode, play_en, oct_up_btn, oct_dn_btn};
            sync <= meta;
        end
    end

    logic [2:0] sw_s;
    logic       auto_s, play_s;
    logic [1:0] btn_s, btn_p;
    assign {sw_s, auto_s, play_s, btn_s} = sync;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_db
            tone_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
                .in_clk     (in_clk),
                .reset_n    (reset_n),
                .level_sync (btn_s[g]),
                .press      (btn_p[g])
            );
        end
    endgenerate

    logic up_p, dn_p;
    assign up_p = btn_p[1];
    assign dn_p = btn_p[0];

    state_t        state, state_nxt;
    logic [TW-1:0] cnt, cnt_nxt;
    logic [2:0]    note_nxt;
    logic [1:0]    oct_nxt;
    logic          tone_nxt;

    always_comb begin
        oct_nxt = octave;
        if (up_p && !dn_p && octave != 2'd2)
            oct_nxt = octave + 2'd1;
        else if (dn_p && !up_p && octave != 2'd0)
            oct_nxt = octave - 2'd1;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + TW'(1);
        note_nxt  = note_idx;
        tone_nxt  = play_s;
        case (state)
            MANUAL: begin
                cnt_nxt  = '0;
                note_nxt = sw_s;
                if (auto_s) begin
                    state_nxt = AUTO_NOTE;
                    note_nxt  = 3'd0;
                end
            end
            AUTO_NOTE: begin
                if (!auto_s) begin
                    state_nxt = MANUAL;
                    cnt_nxt   = '0;
                    note_nxt  = sw_s;
                end else if (cnt == TW'(NOTE_CYCLES - 1)) begin
                    state_nxt = AUTO_GAP;
                    cnt_nxt   = '0;
                    tone_nxt  = 1'b0;
                end
            end
            AUTO_GAP: begin
                tone_nxt = 1'b0;
                if (!auto_s) begin
                    state_nxt = MANUAL;
                    cnt_nxt   = '0;
                    note_nxt  = sw_s;
                    tone_nxt  = play_s;
                end else if (cnt == TW'(GAP_CYCLES - 1)) begin
                    state_nxt = AUTO_NOTE;
                    cnt_nxt   = '0;
                    note_nxt  = note_idx + 3'd1;
                    tone_nxt  = play_s;
                end
            end
            default: begin
                state_nxt = MANUAL;
                cnt_nxt   = '0;
                note_nxt  = 3'd0;
                tone_nxt  = 1'b0;
            end
        endcase
    end

    // freq_out is built from the next-state values so it never lags note_idx/octave
    always_ff @(posedge in_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= MANUAL;
            cnt      <= '0;
            note_idx <= 3'd0;
            octave   <= 2'd0;
            tone_on  <= 1'b0;
            freq_out <= 32'd262;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            note_idx <= note_nxt;
            octave   <= oct_nxt;
            tone_on  <= tone_nxt;
            freq_out <= {20'd0, note_hz(note_nxt)} << oct_nxt;
        end
    end
endmodule

// File: tb/tb_tone_selector.sv
// Directed bench for tone_selector with short debounce/note/gap timings.

module tb_tone_selector;
    logic        in_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  sw = 3'd0;
    logic        auto_mode = 1'b0;
    logic        play_en = 1'b0;
    logic        oct_up_btn = 1'b0;
    logic        oct_dn_btn = 1'b0;
    logic [31:0] freq_out;
    logic [2:0]  note_idx;
    logic [1:0]  octave;
    logic        tone_on;

    int checks = 0;
    int errors = 0;
    int tbl [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

    tone_selector #(
        .CLK_HZ(50_000_000), .DEBOUNCE_CYCLES(4), .NOTE_CYCLES(8), .GAP_CYCLES(2)
    ) dut (
        .in_clk(in_clk), .reset_n(reset_n), .sw(sw), .auto_mode(auto_mode),
        .play_en(play_en), .oct_up_btn(oct_up_btn), .oct_dn_btn(oct_dn_btn),
        .freq_out(freq_out), .note_idx(note_idx), .octave(octave), .tone_on(tone_on)
    );

    always #5 in_clk = ~in_clk;

    task automatic tick(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic press(input logic up, input logic dn);
        oct_up_btn = up;
        oct_dn_btn = dn;
        tick(10);
        oct_up_btn = 1'b0;
        oct_dn_btn = 1'b0;
        tick(10);
    endtask

    task automatic test_reset;
        tick(2);
        checks++;
        if (freq_out !== 32'd262 || note_idx !== 3'd0 || octave !== 2'd0 || tone_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got freq=%0d note=%0d oct=%0d tone=%0b want 262/0/0/0",
                     freq_out, note_idx, octave, tone_on);
        end
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_manual;
        sw = 3'd5;
        play_en = 1'b1;
        tick(2);
        checks++;
        if (note_idx !== 3'd0 || tone_on !== 1'b0) begin
            errors++;
            $display("FAIL manual_latency: got note=%0d tone=%0b after 2 edges want 0/0", note_idx, tone_on);
        end
        tick(1);
        checks++;
        if (freq_out !== 32'd440 || note_idx !== 3'd5 || tone_on !== 1'b1) begin
            errors++;
            $display("FAIL manual_sw5: got freq=%0d note=%0d tone=%0b want 440/5/1", freq_out, note_idx, tone_on);
        end
        sw = 3'd7;
        tick(3);
        checks++;
        if (freq_out !== 32'd523 || note_idx !== 3'd7) begin
            errors++;
            $display("FAIL manual_sw7: got freq=%0d note=%0d want 523/7", freq_out, note_idx);
        end
        sw = 3'd5;
        tick(3);
    endtask

    task automatic test_debounce;
        oct_up_btn = 1'b1;
        tick(3);
        oct_up_btn = 1'b0;
        tick(10);
        checks++;
        if (octave !== 2'd0) begin
            errors++;
            $display("FAIL debounce_glitch: got octave=%0d want 0", octave);
        end
        oct_up_btn = 1'b1;
        tick(6);
        checks++;
        if (octave !== 2'd0) begin
            errors++;
            $display("FAIL debounce_early: got octave=%0d after 6 edges want 0", octave);
        end
        tick(1);
        checks++;
        if (octave !== 2'd1 || freq_out !== 32'd880) begin
            errors++;
            $display("FAIL debounce_held: got octave=%0d freq=%0d want 1/880", octave, freq_out);
        end
        tick(3);
        oct_up_btn = 1'b0;
        tick(10);
        press(1'b1, 1'b0);
        checks++;
        if (octave !== 2'd2 || freq_out !== 32'd1760) begin
            errors++;
            $display("FAIL octave_up2: got octave=%0d freq=%0d want 2/1760", octave, freq_out);
        end
        press(1'b1, 1'b0);
        checks++;
        if (octave !== 2'd2 || freq_out !== 32'd1760) begin
            errors++;
            $display("FAIL octave_sat_hi: got octave=%0d freq=%0d want 2/1760", octave, freq_out);
        end
    endtask

    task automatic test_simultaneous;
        press(1'b0, 1'b1);
        checks++;
        if (octave !== 2'd1 || freq_out !== 32'd880) begin
            errors++;
            $display("FAIL octave_down: got octave=%0d freq=%0d want 1/880", octave, freq_out);
        end
        press(1'b1, 1'b1);
        checks++;
        if (octave !== 2'd1) begin
            errors++;
            $display("FAIL octave_both: got octave=%0d want 1", octave);
        end
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        checks++;
        if (octave !== 2'd0 || freq_out !== 32'd440) begin
            errors++;
            $display("FAIL octave_sat_lo: got octave=%0d freq=%0d want 0/440", octave, freq_out);
        end
    endtask

    task automatic test_auto;
        auto_mode = 1'b1;
        tick(3);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (note_idx !== 3'(k) || freq_out !== 32'(tbl[k]) || tone_on !== 1'b1) begin
                errors++;
                $display("FAIL auto_note_start k=%0d: got note=%0d freq=%0d tone=%0b want %0d/%0d/1",
                         k, note_idx, freq_out, tone_on, k, tbl[k]);
            end
            tick(7);
            checks++;
            if (note_idx !== 3'(k) || tone_on !== 1'b1) begin
                errors++;
                $display("FAIL auto_note_end k=%0d: got note=%0d tone=%0b want %0d/1", k, note_idx, tone_on, k);
            end
            tick(1);
            checks++;
            if (note_idx !== 3'(k) || freq_out !== 32'(tbl[k]) || tone_on !== 1'b0) begin
                errors++;
                $display("FAIL auto_gap k=%0d: got note=%0d freq=%0d tone=%0b want %0d/%0d/0",
                         k, note_idx, freq_out, tone_on, k, tbl[k]);
            end
            tick(2);
        end
        checks++;
        if (note_idx !== 3'd0 || freq_out !== 32'd262 || tone_on !== 1'b1) begin
            errors++;
            $display("FAIL auto_wrap: got note=%0d freq=%0d tone=%0b want 0/262/1", note_idx, freq_out, tone_on);
        end
    endtask

    task automatic test_auto_exit;
        sw = 3'd3;
        tick(6);
        auto_mode = 1'b0;
        tick(2);
        checks++;
        if (note_idx !== 3'd0 || tone_on !== 1'b0) begin
            errors++;
            $display("FAIL exit_in_gap: got note=%0d tone=%0b want 0/0", note_idx, tone_on);
        end
        tick(1);
        checks++;
        if (note_idx !== 3'd3 || freq_out !== 32'd349 || tone_on !== 1'b1) begin
            errors++;
            $display("FAIL exit_manual: got note=%0d freq=%0d tone=%0b want 3/349/1", note_idx, freq_out, tone_on);
        end
        play_en = 1'b0;
        tick(3);
        checks++;
        if (tone_on !== 1'b0 || note_idx !== 3'd3) begin
            errors++;
            $display("FAIL exit_play_off: got tone=%0b note=%0d want 0/3", tone_on, note_idx);
        end
        play_en = 1'b1;
        tick(3);
    endtask

    task automatic test_reset_mid_auto;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        auto_mode = 1'b1;
        tick(8);
        checks++;
        if (octave !== 2'd2 || note_idx !== 3'd0 || freq_out !== 32'd1048) begin
            errors++;
            $display("FAIL pre_reset_auto: got oct=%0d note=%0d freq=%0d want 2/0/1048", octave, note_idx, freq_out);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (freq_out !== 32'd262 || octave !== 2'd0 || tone_on !== 1'b0 || note_idx !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got freq=%0d oct=%0d tone=%0b note=%0d want 262/0/0/0",
                     freq_out, octave, tone_on, note_idx);
        end
        auto_mode = 1'b0;
        sw = 3'd3;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        checks++;
        if (note_idx !== 3'd3 || freq_out !== 32'd349 || octave !== 2'd0 || tone_on !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_manual: got note=%0d freq=%0d oct=%0d tone=%0b want 3/349/0/1",
                     note_idx, freq_out, octave, tone_on);
        end
    endtask

    initial begin
        test_reset;
        test_manual;
        test_debounce;
        test_simultaneous;
        test_auto;
        test_auto_exit;
        test_reset_mid_auto;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
